// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer: pattern width, animation
// mode encodings, bounce direction encodings, per-mode seed patterns and the
// small helpers that map a mode to its successor and to its seed.
// -----------------------------------------------------------------------------
package led_seq_pkg;

   localparam int LED_W     = 8;
   localparam int NUM_MODES = 5;

   typedef enum logic [2:0] {
      MODE_ROT_R  = 3'd0,
      MODE_ROT_L  = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_BLINK  = 3'd3,
      MODE_COUNT  = 3'd4
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [LED_W-1:0] SEED_ROT_R  = 8'h01;
   localparam logic [LED_W-1:0] SEED_ROT_L  = 8'h01;
   localparam logic [LED_W-1:0] SEED_BOUNCE = 8'h01;
   localparam logic [LED_W-1:0] SEED_BLINK  = 8'h0F;
   localparam logic [LED_W-1:0] SEED_COUNT  = 8'h00;

   // Mode that a mode-button press moves to; the last legal mode wraps to 0.
   function automatic mode_e next_mode(input mode_e m);
      if (m == mode_e'(NUM_MODES - 1)) begin
         return MODE_ROT_R;
      end else begin
         return mode_e'(m + 3'd1);
      end
   endfunction

   // Pattern loaded when a mode is entered; illegal encodings fall back to 8'h01.
   function automatic logic [LED_W-1:0] mode_seed(input mode_e m);
      case (m)
         MODE_ROT_R:  return SEED_ROT_R;
         MODE_ROT_L:  return SEED_ROT_L;
         MODE_BOUNCE: return SEED_BOUNCE;
         MODE_BLINK:  return SEED_BLINK;
         MODE_COUNT:  return SEED_COUNT;
         default:     return SEED_ROT_R;
      endcase
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises one raw active-low push-button into clk, debounces it and emits
// a single-cycle pulse when the debounced level goes from released to pressed.
//
// Ports:
//   clk      system clock, posedge
//   rst      synchronous active-low reset
//   btn_n    raw asynchronous button pin, 0 = pressed
//   pressed  one-cycle pulse on an accepted press (release gives no pulse)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pressed
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          stable_r;
   logic [CW-1:0] cnt_r;
   logic          pressed_r;

   logic          stable_nxt_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          pressed_nxt_s;

   // Debounce decision: count consecutive cycles where the synced level differs from the accepted level.
   always_comb begin
      stable_nxt_s  = stable_r;
      cnt_nxt_s     = {CW{1'b0}};
      pressed_nxt_s = 1'b0;
      if (sync2_r == stable_r) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
         // The disagreement has now lasted DEBOUNCE_CYCLES cycles: accept it.
         stable_nxt_s  = sync2_r;
         pressed_nxt_s = ~sync2_r;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1'b1);
      end
   end

   // Synchroniser, debounce state and registered press pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         stable_r  <= 1'b1;
         cnt_r     <= {CW{1'b0}};
         pressed_r <= 1'b0;
      end else begin
         sync1_r   <= btn_n;
         sync2_r   <= sync1_r;
         stable_r  <= stable_nxt_s;
         cnt_r     <= cnt_nxt_s;
         pressed_r <= pressed_nxt_s;
      end
   end

   assign pressed = pressed_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
// Generates a programmable-rate step tick and animates an 8-bit LED pattern
// through five modes. A debounced mode button cycles the animation, a
// debounced speed button cycles the step rate (base rate << speed).
//
// Ports:
//   clk        system clock, posedge
//   rst        synchronous active-low reset
//   btn_mode   raw mode button, active-low
//   btn_speed  raw speed button, active-low
//   led        current pattern
//   mode       current mode encoding
//   speed      current speed level 0..3
//   tick       one-cycle strobe in the cycle the pattern advances
// -----------------------------------------------------------------------------
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int CLK_HZ          = 12_000_000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 120_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_speed,
   output logic [LED_W-1:0] led,
   output logic [2:0]       mode,
   output logic [1:0]       speed,
   output logic             tick
);

   localparam int PRESC0 = CLK_HZ / TICK_HZ;
   localparam int PW     = (PRESC0 > 1) ? $clog2(PRESC0) : 1;

   // Down-counter reload value for a given speed level: period is PRESC0 >> s.
   function automatic logic [PW-1:0] reload_val(input logic [1:0] s);
      return PW'((PRESC0 >> s) - 32'sd1);
   endfunction

   logic             mode_ev_s;
   logic             speed_ev_s;

   logic [LED_W-1:0] led_r;
   mode_e            mode_r;
   dir_e             dir_r;
   logic [1:0]       speed_r;
   logic [PW-1:0]    presc_r;
   logic             tick_r;

   logic [LED_W-1:0] led_nxt_s;
   mode_e            mode_nxt_s;
   dir_e             dir_nxt_s;
   logic [1:0]       speed_nxt_s;
   logic [PW-1:0]    presc_nxt_s;
   logic             tick_nxt_s;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_mode (
      .clk     (clk),
      .rst     (rst),
      .btn_n   (btn_mode),
      .pressed (mode_ev_s)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_speed (
      .clk     (clk),
      .rst     (rst),
      .btn_n   (btn_speed),
      .pressed (speed_ev_s)
   );

   // Next-state logic: button events take precedence over (and swallow) a tick.
   always_comb begin
      led_nxt_s   = led_r;
      mode_nxt_s  = mode_r;
      dir_nxt_s   = dir_r;
      speed_nxt_s = speed_r;
      presc_nxt_s = presc_r - PW'(1'b1);
      tick_nxt_s  = 1'b0;

      if (mode_ev_s || speed_ev_s) begin
         if (mode_ev_s) begin
            mode_nxt_s = next_mode(mode_r);
            led_nxt_s  = mode_seed(next_mode(mode_r));
            dir_nxt_s  = DIR_LEFT;
         end else begin
            mode_nxt_s = mode_r;
            led_nxt_s  = led_r;
            dir_nxt_s  = dir_r;
         end
         if (speed_ev_s) begin
            speed_nxt_s = speed_r + 2'd1;
         end else begin
            speed_nxt_s = speed_r;
         end
         // Restart the step period so the new mode/speed begins with a full period.
         presc_nxt_s = reload_val(speed_nxt_s);
      end else if (presc_r == {PW{1'b0}}) begin
         tick_nxt_s  = 1'b1;
         presc_nxt_s = reload_val(speed_r);
         case (mode_r)
            MODE_ROT_R: begin
               led_nxt_s = {led_r[0], led_r[LED_W-1:1]};
            end
            MODE_ROT_L: begin
               led_nxt_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
            end
            MODE_BOUNCE: begin
               // Reversal happens in the same tick as reaching an end, so the
               // end LED is shown for exactly one step.
               if (dir_r == DIR_LEFT) begin
                  if (led_r == 8'h80) begin
                     dir_nxt_s = DIR_RIGHT;
                     led_nxt_s = {1'b0, led_r[LED_W-1:1]};
                  end else begin
                     led_nxt_s = {led_r[LED_W-2:0], 1'b0};
                  end
               end else begin
                  if (led_r == 8'h01) begin
                     dir_nxt_s = DIR_LEFT;
                     led_nxt_s = {led_r[LED_W-2:0], 1'b0};
                  end else begin
                     led_nxt_s = {1'b0, led_r[LED_W-1:1]};
                  end
               end
            end
            MODE_BLINK: begin
               led_nxt_s = ~led_r;
            end
            MODE_COUNT: begin
               led_nxt_s = led_r + 8'd1;
            end
            default: begin
               // Illegal encoding: recover to the power-on animation.
               mode_nxt_s = MODE_ROT_R;
               led_nxt_s  = SEED_ROT_R;
               dir_nxt_s  = DIR_LEFT;
            end
         endcase
      end else begin
         presc_nxt_s = presc_r - PW'(1'b1);
      end
   end

   // Pattern, mode, speed, prescaler and tick registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_r   <= SEED_ROT_R;
         mode_r  <= MODE_ROT_R;
         dir_r   <= DIR_LEFT;
         speed_r <= 2'd0;
         presc_r <= reload_val(2'd0);
         tick_r  <= 1'b0;
      end else begin
         led_r   <= led_nxt_s;
         mode_r  <= mode_nxt_s;
         dir_r   <= dir_nxt_s;
         speed_r <= speed_nxt_s;
         presc_r <= presc_nxt_s;
         tick_r  <= tick_nxt_s;
      end
   end

   assign led   = led_r;
   assign mode  = mode_r;
   assign speed = speed_r;
   assign tick  = tick_r;

endmodule
